cp0_except: RTL and testbench

- Memory-stage exception arbiter plus CP0 register file for the MIPS pipeline.
- Consumes the M-stage exception flags: load/store address errors (laddrerrM/saddrerrM), fetch address error, RI, syscall, break, overflow, ERET and external interrupts.
- Picks one exception per cycle by fixed priority, then produces the flush and redirect PC.
- Updates Status, Cause, EPC, BadVAddr, Count and Compare, and serves MFC0/MTC0.

---
 rtl/cp0_except_if.sv | 48 ++++
 rtl/cp0_except.sv | 170 +++++++++++++++++
 tb/tb_cp0_except.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_except_if.sv
// M-stage exception flags, MTC0/MFC0 bus and CP0 state outputs shared between
// the pipeline (master) and the CP0 exception block (slave).
interface cp0_except_if;
  logic        validM;
  logic [31:0] pcM;
  logic [31:0] addrs;
  logic        is_in_delayslotM;
  logic        pc_adelM;
  logic        invalidM;
  logic        syscallM;
  logic        breakM;
  logic        overflowM;
  logic        laddrerrM;
  logic        saddrerrM;
  logic        eretM;
  logic [5:0]  int_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] excepttypeM;
  logic        flushexcept;
  logic [31:0] newpcM;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic        timer_int_o;

  modport slave (
    input  validM, pcM, addrs, is_in_delayslotM, pc_adelM, invalidM, syscallM,
           breakM, overflowM, laddrerrM, saddrerrM, eretM, int_i,
           we_i, waddr_i, raddr_i, data_i,
    output data_o, excepttypeM, flushexcept, newpcM, status_o, cause_o,
           epc_o, badvaddr_o, count_o, compare_o, timer_int_o
  );

  modport master (
    output validM, pcM, addrs, is_in_delayslotM, pc_adelM, invalidM, syscallM,
           breakM, overflowM, laddrerrM, saddrerrM, eretM, int_i,
           we_i, waddr_i, raddr_i, data_i,
    input  data_o, excepttypeM, flushexcept, newpcM, status_o, cause_o,
           epc_o, badvaddr_o, count_o, compare_o, timer_int_o
  );
endinterface

// File: rtl/cp0_except.sv
// Memory-stage exception arbiter and CP0 register file (Status, Cause, EPC,
// BadVAddr, Count, Compare) with MFC0/MTC0 access and the Count/Compare timer.
module cp0_except #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input logic        clk,
  input logic        rst,
  cp0_except_if.slave bus
);

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] DIV_LAST     = 32'(COUNT_DIV - 1);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] div_q, div_d;
  logic        timer_int_q, timer_int_d;

  logic        int_m;
  logic        exc_hit;
  logic        eret_hit;
  logic [4:0]  exc_code;
  logic        bad_from_pc;
  logic        bad_from_addr;
  logic        mtc0_en;

  assign int_m = status_q[0] & ~status_q[1] & |(cause_q[15:8] & status_q[15:8]);

  // Fixed-priority pick of one exception; ERET only wins when nothing else fires.
  always_comb begin
    exc_hit       = 1'b0;
    eret_hit      = 1'b0;
    exc_code      = 5'h00;
    bad_from_pc   = 1'b0;
    bad_from_addr = 1'b0;
    if (bus.validM) begin
      if (int_m) begin
        exc_hit = 1'b1; exc_code = 5'h00;
      end else if (bus.pc_adelM) begin
        exc_hit = 1'b1; exc_code = 5'h04; bad_from_pc = 1'b1;
      end else if (bus.invalidM) begin
        exc_hit = 1'b1; exc_code = 5'h0A;
      end else if (bus.syscallM) begin
        exc_hit = 1'b1; exc_code = 5'h08;
      end else if (bus.breakM) begin
        exc_hit = 1'b1; exc_code = 5'h09;
      end else if (bus.overflowM) begin
        exc_hit = 1'b1; exc_code = 5'h0C;
      end else if (bus.laddrerrM) begin
        exc_hit = 1'b1; exc_code = 5'h04; bad_from_addr = 1'b1;
      end else if (bus.saddrerrM) begin
        exc_hit = 1'b1; exc_code = 5'h05; bad_from_addr = 1'b1;
      end else if (bus.eretM) begin
        eret_hit = 1'b1; exc_code = 5'h0E;
      end
    end
  end

  assign bus.excepttypeM = {27'd0, exc_code};
  assign bus.flushexcept = exc_hit | eret_hit;
  assign bus.newpcM      = eret_hit ? epc_q : EXC_VECTOR;
  assign mtc0_en         = bus.we_i & ~(exc_hit | eret_hit);

  always_comb begin
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    count_d     = count_q;
    compare_d   = compare_q;
    div_d       = div_q;
    timer_int_d = timer_int_q;

    cause_d[15:10] = {bus.int_i[5] | timer_int_q, bus.int_i[4:0]};

    if (div_q == DIV_LAST) begin
      count_d = count_q + 32'd1;
      div_d   = 32'd0;
    end else begin
      div_d = div_q + 32'd1;
    end

    if (compare_q != 32'd0 && count_q == compare_q) begin
      timer_int_d = 1'b1;
    end

    if (exc_hit) begin
      if (!status_q[1]) begin
        epc_d      = bus.is_in_delayslotM ? bus.pcM - 32'd4 : bus.pcM;
        cause_d[31] = bus.is_in_delayslotM;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
      if (bad_from_pc) begin
        badvaddr_d = bus.pcM;
      end else if (bad_from_addr) begin
        badvaddr_d = bus.addrs;
      end
    end else if (eret_hit) begin
      status_d[1] = 1'b0;
    end else if (mtc0_en) begin
      case (bus.waddr_i)
        5'd9: begin
          count_d = bus.data_i;
          div_d   = 32'd0;
        end
        5'd11: begin
          compare_d   = bus.data_i;
          timer_int_d = 1'b0;
        end
        5'd12: status_d = (status_q & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
        5'd13: cause_d  = (cause_d & ~CAUSE_WMASK) | (bus.data_i & CAUSE_WMASK);
        5'd14: epc_d    = bus.data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= STATUS_RST;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      badvaddr_q  <= 32'd0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      div_q       <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      div_q       <= div_d;
      timer_int_q <= timer_int_d;
    end
  end

  // MFC0 reads the registered state, so a same-cycle MTC0 is not visible yet.
  always_comb begin
    bus.data_o = 32'd0;
    case (bus.raddr_i)
      5'd8:    bus.data_o = badvaddr_q;
      5'd9:    bus.data_o = count_q;
      5'd11:   bus.data_o = compare_q;
      5'd12:   bus.data_o = status_q;
      5'd13:   bus.data_o = cause_q;
      5'd14:   bus.data_o = epc_q;
      default: bus.data_o = 32'd0;
    endcase
  end

  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.badvaddr_o  = badvaddr_q;
  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_except.sv
// Directed self-checking bench for cp0_except: exception priority, CP0 register
// updates, MTC0/MFC0, Count/Compare timer and mid-run reset.
module tb_cp0_except;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cp0_except_if bus ();

  cp0_except #(.EXC_VECTOR(32'hBFC0_0380), .COUNT_DIV(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.validM = 1'b0; bus.pcM = 32'd0; bus.addrs = 32'd0; bus.is_in_delayslotM = 1'b0;
    bus.pc_adelM = 1'b0; bus.invalidM = 1'b0; bus.syscallM = 1'b0; bus.breakM = 1'b0;
    bus.overflowM = 1'b0; bus.laddrerrM = 1'b0; bus.saddrerrM = 1'b0; bus.eretM = 1'b0;
    bus.int_i = 6'd0; bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.raddr_i = 5'd0; bus.data_i = 32'd0;
  endtask

  task automatic set_flags(input logic [7:0] f);
    {bus.pc_adelM, bus.invalidM, bus.syscallM, bus.breakM,
     bus.overflowM, bus.laddrerrM, bus.saddrerrM, bus.eretM} = f;
  endtask

  task automatic do_eret();
    clear_inputs();
    bus.validM = 1'b1; bus.eretM = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] val);
    clear_inputs();
    bus.we_i = 1'b1; bus.waddr_i = addr; bus.data_i = val;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    checks++; if (bus.status_o !== 32'h0040_0000) begin errors++; $display("[TB] FAIL reset_status: got %h expected %h", bus.status_o, 32'h0040_0000); end
    checks++; if (bus.cause_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_cause: got %h expected 0", bus.cause_o); end
    checks++; if (bus.epc_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_epc: got %h expected 0", bus.epc_o); end
    checks++; if (bus.badvaddr_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_badvaddr: got %h expected 0", bus.badvaddr_o); end
    checks++; if (bus.count_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %h expected 0", bus.count_o); end
    checks++; if (bus.compare_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_compare: got %h expected 0", bus.compare_o); end
    checks++; if (bus.timer_int_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_timer: got %b expected 0", bus.timer_int_o); end
    checks++; if (bus.flushexcept !== 1'b0 || bus.excepttypeM !== 32'd0) begin errors++; $display("[TB] FAIL reset_flush: got %b/%h expected 0/0", bus.flushexcept, bus.excepttypeM); end
    rst = 1'b0;
  endtask

  task automatic test_load_adel();
    clear_inputs();
    bus.validM = 1'b1; bus.laddrerrM = 1'b1; bus.addrs = 32'h8000_0002; bus.pcM = 32'hBFC0_0100;
    #1;
    checks++; if (bus.excepttypeM !== 32'h04) begin errors++; $display("[TB] FAIL ladel_type: got %h expected 04", bus.excepttypeM); end
    checks++; if (bus.flushexcept !== 1'b1) begin errors++; $display("[TB] FAIL ladel_flush: got %b expected 1", bus.flushexcept); end
    checks++; if (bus.newpcM !== 32'hBFC0_0380) begin errors++; $display("[TB] FAIL ladel_newpc: got %h expected bfc00380", bus.newpcM); end
    tick();
    clear_inputs();
    checks++; if (bus.badvaddr_o !== 32'h8000_0002) begin errors++; $display("[TB] FAIL ladel_badvaddr: got %h expected 80000002", bus.badvaddr_o); end
    checks++; if (bus.epc_o !== 32'hBFC0_0100) begin errors++; $display("[TB] FAIL ladel_epc: got %h expected bfc00100", bus.epc_o); end
    checks++; if (bus.status_o !== 32'h0040_0002) begin errors++; $display("[TB] FAIL ladel_status: got %h expected 00400002", bus.status_o); end
    checks++; if (bus.cause_o[6:2] !== 5'h04) begin errors++; $display("[TB] FAIL ladel_exccode: got %h expected 04", bus.cause_o[6:2]); end
    bus.validM = 1'b1; bus.eretM = 1'b1;
    #1;
    checks++; if (bus.newpcM !== 32'hBFC0_0100) begin errors++; $display("[TB] FAIL eret_newpc: got %h expected bfc00100", bus.newpcM); end
    checks++; if (bus.excepttypeM !== 32'h0E || bus.flushexcept !== 1'b1) begin errors++; $display("[TB] FAIL eret_type: got %h/%b expected 0e/1", bus.excepttypeM, bus.flushexcept); end
    tick();
    clear_inputs();
    checks++; if (bus.status_o !== 32'h0040_0000) begin errors++; $display("[TB] FAIL eret_status: got %h expected 00400000", bus.status_o); end
  endtask

  task automatic test_store_delayslot();
    clear_inputs();
    bus.validM = 1'b1; bus.saddrerrM = 1'b1; bus.is_in_delayslotM = 1'b1;
    bus.pcM = 32'hBFC0_0204; bus.addrs = 32'h1234_5679;
    tick();
    clear_inputs();
    checks++; if (bus.epc_o !== 32'hBFC0_0200) begin errors++; $display("[TB] FAIL ades_epc: got %h expected bfc00200", bus.epc_o); end
    checks++; if (bus.cause_o[31] !== 1'b1) begin errors++; $display("[TB] FAIL ades_bd: got %b expected 1", bus.cause_o[31]); end
    checks++; if (bus.cause_o[6:2] !== 5'h05) begin errors++; $display("[TB] FAIL ades_exccode: got %h expected 05", bus.cause_o[6:2]); end
    checks++; if (bus.badvaddr_o !== 32'h1234_5679) begin errors++; $display("[TB] FAIL ades_badvaddr: got %h expected 12345679", bus.badvaddr_o); end
    do_eret();
  endtask

  task automatic test_priority();
    logic [7:0] flags [8];
    logic [4:0] codes [8];
    flags = '{8'b1111_1111, 8'b0111_1111, 8'b0011_1111, 8'b0001_1111,
              8'b0000_1111, 8'b0000_0111, 8'b0000_0011, 8'b0000_0001};
    codes = '{5'h04, 5'h0A, 5'h08, 5'h09, 5'h0C, 5'h04, 5'h05, 5'h0E};
    clear_inputs();
    bus.validM = 1'b1; bus.overflowM = 1'b1; bus.laddrerrM = 1'b1;
    bus.addrs = 32'hDEAD_0001; bus.pcM = 32'hBFC0_0400;
    #1;
    checks++; if (bus.excepttypeM !== 32'h0C) begin errors++; $display("[TB] FAIL ov_type: got %h expected 0c", bus.excepttypeM); end
    tick();
    checks++; if (bus.cause_o[6:2] !== 5'h0C) begin errors++; $display("[TB] FAIL ov_exccode: got %h expected 0c", bus.cause_o[6:2]); end
    checks++; if (bus.badvaddr_o !== 32'h1234_5679) begin errors++; $display("[TB] FAIL ov_badvaddr: got %h expected 12345679", bus.badvaddr_o); end
    checks++; if (bus.epc_o !== 32'hBFC0_0400) begin errors++; $display("[TB] FAIL ov_epc: got %h expected bfc00400", bus.epc_o); end
    bus.validM = 1'b0; bus.pcM = 32'hBFC0_0500; bus.addrs = 32'h0000_0003;
    #1;
    checks++; if (bus.flushexcept !== 1'b0 || bus.excepttypeM !== 32'd0) begin errors++; $display("[TB] FAIL bubble_flush: got %b/%h expected 0/0", bus.flushexcept, bus.excepttypeM); end
    tick();
    checks++; if (bus.epc_o !== 32'hBFC0_0400 || bus.badvaddr_o !== 32'h1234_5679 || bus.status_o !== 32'h0040_0002) begin errors++; $display("[TB] FAIL bubble_regs: got %h/%h/%h expected bfc00400/12345679/00400002", bus.epc_o, bus.badvaddr_o, bus.status_o); end
    do_eret();
    bus.validM = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_flags(flags[i]);
      #1;
      checks++; if (bus.excepttypeM !== {27'd0, codes[i]} || bus.flushexcept !== 1'b1) begin errors++; $display("[TB] FAIL prio_row%0d: got %h/%b expected %h/1", i, bus.excepttypeM, bus.flushexcept, codes[i]); end
    end
    set_flags(8'd0);
    #1;
    checks++; if (bus.excepttypeM !== 32'd0 || bus.flushexcept !== 1'b0) begin errors++; $display("[TB] FAIL prio_none: got %h/%b expected 0/0", bus.excepttypeM, bus.flushexcept); end
    clear_inputs();
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    checks++; if (bus.status_o !== 32'h0040_0401) begin errors++; $display("[TB] FAIL int_status_wr: got %h expected 00400401", bus.status_o); end
    bus.int_i = 6'b000001;
    tick();
    checks++; if (bus.cause_o[15:8] !== 8'h04) begin errors++; $display("[TB] FAIL int_ip: got %h expected 04", bus.cause_o[15:8]); end
    bus.validM = 1'b1; bus.pcM = 32'hBFC0_0300;
    #1;
    checks++; if (bus.excepttypeM !== 32'd0 || bus.flushexcept !== 1'b1) begin errors++; $display("[TB] FAIL int_take: got %h/%b expected 0/1", bus.excepttypeM, bus.flushexcept); end
    bus.int_i = 6'd0;
    tick();
    clear_inputs();
    checks++; if (bus.status_o !== 32'h0040_0403 || bus.cause_o[6:2] !== 5'h00) begin errors++; $display("[TB] FAIL int_state: got %h/%h expected 00400403/00", bus.status_o, bus.cause_o[6:2]); end
    checks++; if (bus.epc_o !== 32'hBFC0_0300) begin errors++; $display("[TB] FAIL int_epc: got %h expected bfc00300", bus.epc_o); end
    bus.validM = 1'b1; bus.eretM = 1'b1;
    #1;
    checks++; if (bus.newpcM !== 32'hBFC0_0300) begin errors++; $display("[TB] FAIL int_eret_newpc: got %h expected bfc00300", bus.newpcM); end
    tick();
    clear_inputs();
    checks++; if (bus.status_o !== 32'h0040_0401) begin errors++; $display("[TB] FAIL int_eret_exl: got %h expected 00400401", bus.status_o); end
    mtc0(5'd12, 32'h0000_0000);
  endtask

  task automatic test_timer();
    int  n;
    logic seen;
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = bus.timer_int_o;
    end
    checks++; if (!seen || n < 20 || n > 22) begin errors++; $display("[TB] FAIL timer_rise: got seen=%b after %0d cycles expected rise near 20", seen, n); end
    checks++; if (bus.count_o !== 32'd10) begin errors++; $display("[TB] FAIL timer_count: got %0d expected 10", bus.count_o); end
    tick();
    checks++; if (bus.cause_o[15] !== 1'b1 || bus.timer_int_o !== 1'b1) begin errors++; $display("[TB] FAIL timer_ip15: got %b/%b expected 1/1", bus.cause_o[15], bus.timer_int_o); end
    mtc0(5'd11, 32'd100);
    checks++; if (bus.timer_int_o !== 1'b0) begin errors++; $display("[TB] FAIL timer_clear: got %b expected 0", bus.timer_int_o); end
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick(); tick();
    checks++; if (bus.count_o !== 32'd0) begin errors++; $display("[TB] FAIL count_wrap: got %h expected 0", bus.count_o); end
  endtask

  task automatic test_exl_hold();
    clear_inputs();
    bus.validM = 1'b1; bus.syscallM = 1'b1; bus.pcM = 32'h0000_0100;
    tick();
    clear_inputs();
    checks++; if (bus.epc_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL sys_epc: got %h expected 00000100", bus.epc_o); end
    bus.validM = 1'b1; bus.breakM = 1'b1; bus.pcM = 32'h0000_0200;
    tick();
    clear_inputs();
    checks++; if (bus.epc_o !== 32'h0000_0100 || bus.cause_o[6:2] !== 5'h09) begin errors++; $display("[TB] FAIL exl_hold: got %h/%h expected 00000100/09", bus.epc_o, bus.cause_o[6:2]); end
    bus.validM = 1'b1; bus.syscallM = 1'b1; bus.pcM = 32'h0000_0300;
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'h0000_5555;
    tick();
    clear_inputs();
    checks++; if (bus.epc_o !== 32'h0000_0100 || bus.cause_o[6:2] !== 5'h08) begin errors++; $display("[TB] FAIL mtc0_suppress: got %h/%h expected 00000100/08", bus.epc_o, bus.cause_o[6:2]); end
    mtc0(5'd14, 32'h0000_5555);
    checks++; if (bus.epc_o !== 32'h0000_5555) begin errors++; $display("[TB] FAIL epc_write: got %h expected 00005555", bus.epc_o); end
    bus.raddr_i = 5'd14; bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'h0000_6666;
    #1;
    checks++; if (bus.data_o !== 32'h0000_5555) begin errors++; $display("[TB] FAIL mfc0_nobypass: got %h expected 00005555", bus.data_o); end
    tick();
    bus.we_i = 1'b0;
    #1;
    checks++; if (bus.data_o !== 32'h0000_6666) begin errors++; $display("[TB] FAIL mfc0_epc: got %h expected 00006666", bus.data_o); end
    bus.raddr_i = 5'd8;
    #1;
    checks++; if (bus.data_o !== 32'h1234_5679) begin errors++; $display("[TB] FAIL mfc0_badvaddr: got %h expected 12345679", bus.data_o); end
    bus.raddr_i = 5'd5;
    #1;
    checks++; if (bus.data_o !== 32'd0) begin errors++; $display("[TB] FAIL mfc0_unmapped: got %h expected 0", bus.data_o); end
    bus.raddr_i = 5'd12;
    #1;
    checks++; if (bus.data_o !== 32'h0040_0002) begin errors++; $display("[TB] FAIL mfc0_status: got %h expected 00400002", bus.data_o); end
    clear_inputs();
  endtask

  task automatic test_midreset();
    clear_inputs();
    bus.validM = 1'b1; bus.syscallM = 1'b1; bus.pcM = 32'h0000_0700;
    rst = 1'b1;
    tick();
    checks++; if (bus.status_o !== 32'h0040_0000 || bus.cause_o !== 32'd0 || bus.epc_o !== 32'd0) begin errors++; $display("[TB] FAIL midrst_regs: got %h/%h/%h expected 00400000/0/0", bus.status_o, bus.cause_o, bus.epc_o); end
    checks++; if (bus.badvaddr_o !== 32'd0 || bus.count_o !== 32'd0 || bus.compare_o !== 32'd0 || bus.timer_int_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_timer: got %h/%h/%h/%b expected 0/0/0/0", bus.badvaddr_o, bus.count_o, bus.compare_o, bus.timer_int_o); end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_adel();
    test_store_delayslot();
    test_priority();
    test_interrupt();
    test_timer();
    test_exl_hold();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
